// File: rtl/mem_io_pkg.sv
// Shared address map and decode helper for the memory / I/O responder.
package mem_io_pkg;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [31:0] IO_UART = 32'h0003_0000;
    localparam logic [31:0] IO_CTRL = 32'h0003_0004;
    localparam int          IO_SEL_HI = 17;
    localparam int          IO_SEL_LO = 16;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_UART,
        SEL_CTRL,
        SEL_NONE
    } io_sel_e;

    // Only bits 17:0 take part in decode; the upper address bits alias.
    function automatic io_sel_e io_decode(input logic [17:0] a);
        if (a[IO_SEL_HI:IO_SEL_LO] != IO_BASE[IO_SEL_HI:IO_SEL_LO]) return SEL_RAM;
        if (a == IO_UART[17:0]) return SEL_UART;
        if (a == IO_CTRL[17:0]) return SEL_CTRL;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO; a push while full is taken only when a pop happens the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Bus responder: byte RAM plus memory-mapped UART FIFOs, status and halt registers.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 17,
    parameter int    FIFO_DEPTH  = 16,
    parameter int    FULL_MARGIN = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] ctrl_a,
    input  logic        ctrl_wr,
    input  logic [7:0]  ctrl_wdata,
    output logic [7:0]  ctrl_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic        sim_halt,
    output logic        tx_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    ram [2**ADDR_WIDTH];
    io_sel_e       sel;
    logic          unused_hi;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_dout;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;

    assign sel       = io_decode(ctrl_a[17:0]);
    assign unused_hi = ^{ctrl_a[31:18], rx_count};

    assign tx_pop  = uart_tx_valid & uart_tx_ready;
    assign tx_push = rdy_in & ctrl_wr & (sel == SEL_UART);
    assign rx_push = uart_rx_valid & uart_rx_ready;
    assign rx_pop  = rdy_in & ~ctrl_wr & (sel == SEL_UART) & ~rx_empty;

    assign uart_tx_valid  = ~tx_empty;
    assign uart_rx_ready  = ~rx_full;
    // Decoded from the registered count, so it tracks the post-edge fill level.
    assign io_buffer_full = (tx_count >= CW'(FIFO_DEPTH - FULL_MARGIN));

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (ctrl_wdata),
        .dout  (uart_tx_data),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (uart_rx_data),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // RAM has no reset so its contents survive a mid-run reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && ctrl_wr && sel == SEL_RAM) ram[ctrl_a[ADDR_WIDTH-1:0]] <= ctrl_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ctrl_rdata  <= '0;
            sim_halt    <= 1'b0;
            tx_overflow <= 1'b0;
        end else if (rdy_in) begin
            if (ctrl_wr) begin
                if (sel == SEL_UART && tx_full && !tx_pop) tx_overflow <= 1'b1;
                if (sel == SEL_CTRL) sim_halt <= 1'b1;
            end else begin
                case (sel)
                    SEL_RAM:  ctrl_rdata <= ram[ctrl_a[ADDR_WIDTH-1:0]];
                    SEL_UART: ctrl_rdata <= rx_empty ? 8'h00 : rx_dout;
                    SEL_CTRL: ctrl_rdata <= {6'b0, ~rx_empty, tx_full};
                    default:  ctrl_rdata <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized and directed bench for mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  wd;
    logic [7:0]  rdata;
    logic        ibf;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] ram_m [int];
    logic [7:0] m_rdata;
    bit         m_known;
    bit         m_halt;
    bit         m_ovf;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .rdy_in         (rdy),
        .ctrl_a         (a),
        .ctrl_wr        (wr),
        .ctrl_wdata     (wd),
        .ctrl_rdata     (rdata),
        .io_buffer_full (ibf),
        .uart_tx_data   (tx_data),
        .uart_tx_valid  (tx_valid),
        .uart_tx_ready  (tx_ready),
        .uart_rx_data   (rx_data),
        .uart_rx_valid  (rx_valid),
        .uart_rx_ready  (rx_ready),
        .sim_halt       (halt),
        .tx_overflow    (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_rdata = 8'h00;
        m_known = 1'b1;
        m_halt  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_all();
        if (m_known) chk("rdata", rdata, m_rdata);
        chk("ibf", ibf, (txq.size() >= 14));
        chk("tx_valid", tx_valid, (txq.size() > 0));
        if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
        chk("rx_ready", rx_ready, (rxq.size() < 16));
        chk("halt", halt, m_halt);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic set(input logic r, input logic [31:0] addr, input logic w, input logic [7:0] d);
        rdy = r;
        a   = addr;
        wr  = w;
        wd  = d;
    endtask

    // One bus cycle: model absorbs the inputs seen at the edge, then outputs are compared.
    task automatic step();
        bit         is_io, tx_pop, rx_push, do_push;
        logic [17:0] lo;
        int          ra;
        @(posedge clk);
        lo      = a[17:0];
        is_io   = (a[17:16] == 2'b11);
        ra      = int'(a[16:0]);
        tx_pop  = (txq.size() > 0) && tx_ready;
        rx_push = rx_valid && (rxq.size() < 16);
        do_push = 1'b0;
        if (rdy) begin
            if (wr) begin
                if (!is_io) ram_m[ra] = wd;
                else if (lo == 18'h30000) begin
                    if (txq.size() < 16 || tx_pop) do_push = 1'b1;
                    else m_ovf = 1'b1;
                end else if (lo == 18'h30004) m_halt = 1'b1;
            end else begin
                if (!is_io) begin
                    m_known = ram_m.exists(ra);
                    if (m_known) m_rdata = ram_m[ra];
                end else if (lo == 18'h30000) begin
                    m_rdata = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
                    m_known = 1'b1;
                end else if (lo == 18'h30004) begin
                    m_rdata = {6'b0, rxq.size() > 0, txq.size() == 16};
                    m_known = 1'b1;
                end else begin
                    m_rdata = 8'h00;
                    m_known = 1'b1;
                end
            end
        end
        if (tx_pop)  void'(txq.pop_front());
        if (do_push) txq.push_back(wd);
        if (rx_push) rxq.push_back(rx_data);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] old;
        rst_n = 1'b0;
        set(1'b1, 32'h0, 1'b0, 8'h00);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        #12;
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_ibf", ibf, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_halt", halt, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // read-after-write
        set(1'b1, 32'h0000_1234, 1'b1, 8'hA5); step();
        set(1'b1, 32'h0000_1234, 1'b0, 8'h00); step();
        chk("raw_a5", rdata, 8'hA5);
        set(1'b1, 32'h0000_1235, 1'b0, 8'h00); step();

        // known contents for the random window
        for (int i = 0; i < 64; i++) begin
            set(1'b1, 32'(i), 1'b1, 8'($urandom)); step();
        end
        set(1'b1, 32'h0, 1'b0, 8'h00); step();

        // TX threshold, overflow and ordered drain
        for (int i = 0; i < 17; i++) begin
            set(1'b1, 32'h0003_0000, 1'b1, 8'h10 + 8'(i)); step();
            if (i == 12) chk("ibf_13", ibf, 1'b0);
            if (i == 13) chk("ibf_14", ibf, 1'b1);
            if (i == 15) chk("ovf_16", ovf, 1'b0);
            if (i == 16) chk("ovf_17", ovf, 1'b1);
        end
        set(1'b1, 32'h0003_0004, 1'b0, 8'h00); step();
        chk("status_txfull", rdata, 8'h01);
        set(1'b1, 32'h0, 1'b0, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", tx_data, 8'h10 + 8'(i));
            step();
        end
        chk("drain_done", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // RX reads
        set(1'b1, 32'h0003_0000, 1'b0, 8'h00); step();
        chk("rx_empty_rd", rdata, 8'h00);
        set(1'b1, 32'h0, 1'b0, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h41; step();
        rx_data = 8'h42; step();
        rx_valid = 1'b0;
        set(1'b1, 32'h0003_0000, 1'b0, 8'h00); step();
        chk("rx_first", rdata, 8'h41);
        step();
        chk("rx_second", rdata, 8'h42);
        set(1'b1, 32'h0003_0004, 1'b0, 8'h00); step();
        chk("status_idle", rdata, 8'h00);

        // rdy_in low freezes the bus side
        rx_valid = 1'b1; rx_data = 8'h55; step();
        rx_valid = 1'b0;
        set(1'b1, 32'h0000_0010, 1'b0, 8'h00); step();
        old = ram_m[16];
        set(1'b0, 32'h0000_0010, 1'b1, 8'h77); step();
        set(1'b0, 32'h0003_0000, 1'b0, 8'h00); step();
        chk("frz_rdata", rdata, old);
        set(1'b1, 32'h0000_0010, 1'b0, 8'h00); step();
        chk("frz_ram", rdata, old);
        set(1'b1, 32'h0003_0004, 1'b0, 8'h00); step();
        chk("frz_rx_kept", rdata, 8'h02);
        set(1'b1, 32'h0000_0010, 1'b1, 8'h77); step();
        set(1'b1, 32'h0000_0010, 1'b0, 8'h00); step();
        chk("thaw_wr", rdata, 8'h77);
        set(1'b1, 32'h0003_0000, 1'b0, 8'h00); step();
        chk("thaw_rx", rdata, 8'h55);

        // halt through an aliased address
        set(1'b1, 32'hFFFF_0004, 1'b1, 8'h3C); step();
        chk("halt_set", halt, 1'b1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] addr;
            case ($urandom_range(0, 5))
                0, 1:    addr = {$urandom_range(0, 16383) << 18} | 32'h0003_0000;
                2:       addr = {$urandom_range(0, 16383) << 18} | 32'h0003_0004;
                3:       addr = 32'h0003_0008 + 32'($urandom_range(0, 3) * 4);
                default: addr = {$urandom_range(0, 16383) << 18} | 32'($urandom_range(0, 63));
            endcase
            set(($urandom_range(0, 9) != 0), addr, 1'($urandom), 8'($urandom));
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            step();
        end
        chk("halt_sticky", halt, 1'b1);

        // asynchronous reset while the TX FIFO is busy
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        set(1'b1, 32'h0, 1'b0, 8'h00); step();
        for (int i = 0; i < 6; i++) begin
            set(1'b1, 32'h0003_0000, 1'b1, 8'hC0 + 8'(i)); step();
        end
        set(1'b1, 32'h0, 1'b0, 8'h00);
        tx_ready = 1'b1;
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_ibf", ibf, 1'b0);
        chk("arst_halt", halt, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        chk("arst_rdata", rdata, 8'h00);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set(1'b1, 32'h0000_1234, 1'b0, 8'h00); step();
        chk("ret_a5", rdata, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
